// File: rtl/video_line_buf_ctrl_pkg.sv
// ============================================================================
// video_pkg : shared types and defaults for the video line-buffer path
// Rev 1.0
// ============================================================================
`default_nettype none

package video_pkg;

  localparam int C_DATA_W = 24;  // {blue,green,red}, 8 bits each
  localparam int C_ADDR_W = 10;
  localparam int C_LINE_W = 10;  // line-number width, shared with the timing generator

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/video_line_buf_ctrl.sv
// ============================================================================
// video_line_buf_ctrl : ping-pong line-buffer fill controller with underrun flag
// Rev 1.0
// ============================================================================
`default_nettype none

module video_line_buf_ctrl
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int DATA_W   = C_DATA_W,
  parameter int ADDR_W   = C_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                line_start,
  output logic                fill_req,
  output logic [C_LINE_W-1:0] fill_line,
  input  logic                src_valid,
  input  logic [DATA_W-1:0]   src_data,
  output logic                src_ready,
  output logic                src_flush,
  output logic                wr_en_0,
  output logic                wr_en_1,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                rd_sel,
  output logic                underrun,
  output logic [15:0]         underrun_cnt
);

  localparam logic [ADDR_W-1:0]   c_last_word = ADDR_W'(H_ACTIVE - 1);
  localparam logic [C_LINE_W-1:0] c_last_line = C_LINE_W'(V_ACTIVE - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_word_cnt;
  logic [C_LINE_W-1:0] r_line_idx;

  logic w_in_fill;
  logic w_active;
  logic w_beat;
  logic w_last_word;
  logic w_advance;
  logic w_underrun;
  logic w_write;

  assign w_in_fill   = (r_state == ST_FILL);
  assign w_active    = w_in_fill || (r_state == ST_READY);
  assign w_beat      = src_valid && w_in_fill;
  assign w_last_word = (r_word_cnt == c_last_word);
  // frame_start overrides line_start; a final beat landing with line_start is on time
  assign w_advance   = line_start && !frame_start && w_active;
  assign w_underrun  = w_advance && w_in_fill && !(w_beat && w_last_word);
  assign w_write     = w_beat && !frame_start && !w_underrun;

  assign src_ready   = w_in_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_word_cnt   <= '0;
      r_line_idx   <= '0;
      fill_req     <= 1'b0;
      fill_line    <= '0;
      src_flush    <= 1'b0;
      wr_en_0      <= 1'b0;
      wr_en_1      <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rd_sel       <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      fill_req  <= 1'b0;
      src_flush <= 1'b0;
      wr_en_0   <= 1'b0;
      wr_en_1   <= 1'b0;
      underrun  <= 1'b0;

      // the fill buffer is always the one not being scanned out
      if (w_write) begin
        wr_data    <= src_data;
        wr_addr    <= r_word_cnt;
        wr_en_0    <= rd_sel;
        wr_en_1    <= ~rd_sel;
        r_word_cnt <= r_word_cnt + 1'b1;
      end

      if (w_underrun) begin
        underrun  <= 1'b1;
        src_flush <= 1'b1;
        if (underrun_cnt != 16'hFFFF)
          underrun_cnt <= underrun_cnt + 16'd1;
      end

      if (frame_start) begin
        if (w_active)
          src_flush <= 1'b1;
        rd_sel     <= 1'b0;
        r_line_idx <= '0;
        fill_line  <= '0;
        fill_req   <= 1'b1;
        r_word_cnt <= '0;
        r_state    <= ST_FILL;
      end else if (w_advance) begin
        rd_sel     <= ~rd_sel;
        r_line_idx <= r_line_idx + 1'b1;
        if (r_line_idx == c_last_line) begin
          r_state <= ST_DRAIN;
        end else begin
          fill_line  <= r_line_idx + 1'b1;
          fill_req   <= 1'b1;
          r_word_cnt <= '0;
          r_state    <= ST_FILL;
        end
      end else if (w_write && w_last_word) begin
        r_state <= ST_READY;
      end
    end
  end

endmodule

`default_nettype wire
